// File: rtl/response_router_pkg.sv
// response_router_pkg: shared widths, response record and the saturating drop-count helper.
// RESP_PORT_SEL_BIT is the in_id bit that picks the destination port (0 = port 1, 1 = port 2).
package response_router_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ID_WIDTH = 8;
  localparam int RESP_PORT_SEL_BIT = ID_WIDTH - 1;
  localparam int RESP_WIDTH = DATA_WIDTH + ID_WIDTH;
  localparam logic [7:0] DROP_CNT_MAX = 8'hff;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0] id;
  } resp_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == DROP_CNT_MAX ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: power-of-two deep FIFO with occupancy count; a push while full is taken only alongside a pop.
// Pointers wrap naturally because DEPTH is a power of two.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/response_router.sv
// response_router: steers responses by in_id MSB into two stallable output FIFOs, dropping pushes into a full, non-popping FIFO.
// Optional saturating drop_count port and counter are built only when RESP_DROP_CNT_EN is defined.
module response_router
  import response_router_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic                  in_valid,
  output logic                  out_almost_full,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [ID_WIDTH-1:0]   out_id_1,
  output logic                  out_valid_1,
  input  logic                  in_stall_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [ID_WIDTH-1:0]   out_id_2,
  output logic                  out_valid_2,
  input  logic                  in_stall_2
`ifdef RESP_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic sel_2, push_1, push_2, pop_1, pop_2, full_1, full_2, empty_1, empty_2;
  logic [CW-1:0] count_1, count_2;
  resp_t wr, rd_1, rd_2;
  always_comb begin
    wr = '{data: in_data, id: in_id};
    sel_2 = in_id[RESP_PORT_SEL_BIT];
    pop_1 = !empty_1 && !in_stall_1;
    pop_2 = !empty_2 && !in_stall_2;
    push_1 = in_valid && !sel_2 && (!full_1 || pop_1);
    push_2 = in_valid && sel_2 && (!full_2 || pop_2);
  end
  resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RESP_WIDTH)) u_fifo_1 (
    .clk(clk), .reset(reset), .push(push_1), .pop(pop_1), .wdata(wr), .rdata(rd_1),
    .full(full_1), .empty(empty_1), .count(count_1)
  );
  resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RESP_WIDTH)) u_fifo_2 (
    .clk(clk), .reset(reset), .push(push_2), .pop(pop_2), .wdata(wr), .rdata(rd_2),
    .full(full_2), .empty(empty_2), .count(count_2)
  );
  assign out_valid_1 = !empty_1;
  assign out_data_1 = rd_1.data;
  assign out_id_1 = rd_1.id;
  assign out_valid_2 = !empty_2;
  assign out_data_2 = rd_2.data;
  assign out_id_2 = rd_2.id;
  assign out_almost_full = count_1 >= CW'(FIFO_DEPTH - 1) || count_2 >= CW'(FIFO_DEPTH - 1);
`ifdef RESP_DROP_CNT_EN
  logic drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  assign drop_count = drop_cnt_q;
  always_comb begin
    drop = in_valid && (sel_2 ? full_2 && !pop_2 : full_1 && !pop_1);
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
`endif
endmodule

// File: tb/tb_response_router.sv
// tb_response_router: directed and random stimulus against a queue-based model of the two output FIFOs.
module tb_response_router;
  localparam int DEPTH = 4;
  logic clk, reset, in_valid, in_stall_1, in_stall_2;
  logic [15:0] in_data, out_data_1, out_data_2;
  logic [7:0] in_id, out_id_1, out_id_2;
  logic out_valid_1, out_valid_2, out_almost_full;
`ifdef RESP_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  int checks = 0;
  int failures = 0;
  logic [23:0] q1[$];
  logic [23:0] q2[$];
  int drops = 0;

  response_router #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
    .out_almost_full(out_almost_full),
    .out_data_1(out_data_1), .out_id_1(out_id_1), .out_valid_1(out_valid_1), .in_stall_1(in_stall_1),
    .out_data_2(out_data_2), .out_id_2(out_id_2), .out_valid_2(out_valid_2), .in_stall_2(in_stall_2)
`ifdef RESP_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid_1", 32'(out_valid_1), 32'(q1.size() != 0));
    chk("valid_2", 32'(out_valid_2), 32'(q2.size() != 0));
    chk("almost_full", 32'(out_almost_full), 32'(q1.size() >= DEPTH - 1 || q2.size() >= DEPTH - 1));
    if (q1.size() != 0) chk("head_1", {8'h0, out_data_1, out_id_1}, {8'h0, q1[0]});
    if (q2.size() != 0) chk("head_2", {8'h0, out_data_2, out_id_2}, {8'h0, q2[0]});
`ifdef RESP_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(drops));
`endif
  endtask

  task automatic offer(inout logic [23:0] q[$], input logic [23:0] r);
    if (q.size() < DEPTH) q.push_back(r);
    else if (drops < 255) drops++;
  endtask

  task automatic step(input logic v, input logic [7:0] id, input logic [15:0] d, input logic s1, input logic s2);
    bit p1, p2;
    in_valid = v; in_id = id; in_data = d; in_stall_1 = s1; in_stall_2 = s2;
    check_outputs();
    p1 = q1.size() != 0 && !s1;
    p2 = q2.size() != 0 && !s2;
    @(posedge clk);
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (v && id[7]) offer(q2, {d, id});
    if (v && !id[7]) offer(q1, {d, id});
    #1;
  endtask

  initial begin
    clk = 0; reset = 1; in_valid = 0; in_id = 0; in_data = 0; in_stall_1 = 0; in_stall_2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_1", 32'(out_valid_1), 0);
    chk("rst_valid_2", 32'(out_valid_2), 0);
    chk("rst_almost_full", 32'(out_almost_full), 0);
`ifdef RESP_DROP_CNT_EN
    chk("rst_drop_count", 32'(drop_count), 0);
`endif
    reset = 0;
    step(1, 8'h00, 16'h00a5, 0, 0);
    chk("single_valid_1", 32'(out_valid_1), 1);
    chk("single_data_1", 32'(out_data_1), 32'h00a5);
    chk("single_valid_2", 32'(out_valid_2), 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h80 + 8'(i), 16'h1000 + 16'(i), 0, 1);
      if (i == 2) chk("af_after_3", 32'(out_almost_full), 1);
    end
    chk("stalled_id_2", 32'(out_id_2), 32'h80);
    step(1, 8'h84, 16'h1004, 0, 1);
    chk("held_id_2", 32'(out_id_2), 32'h80);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h01 + 8'(i), 16'h2000 + 16'(i), 1, 0);
    step(1, 8'h09, 16'h2009, 1, 0);
    chk("drop_head_1", 32'(out_id_1), 32'h01);
    step(1, 8'h05, 16'h2005, 0, 0);
    chk("full_pp_af", 32'(out_almost_full), 1);
    chk("full_pp_head", 32'(out_id_1), 32'h02);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, {i[0], 7'(8'h10 + 8'(i))}, 16'h3000 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 270; i++) step(1, 8'h01, 16'(i), 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 8'h07, 16'h4000 + 16'(i), 1, 1);
    for (int i = 0; i < 2; i++) step(1, 8'h87, 16'h5000 + 16'(i), 1, 1);
    #2 reset = 1;
    #1;
    q1.delete(); q2.delete(); drops = 0;
    chk("async_rst_valid_1", 32'(out_valid_1), 0);
    chk("async_rst_valid_2", 32'(out_valid_2), 0);
    chk("async_rst_af", 32'(out_almost_full), 0);
`ifdef RESP_DROP_CNT_EN
    chk("async_rst_drop_count", 32'(drop_count), 0);
`endif
    @(posedge clk);
    #1 reset = 0;
    step(1, 8'h00, 16'h00a5, 0, 0);
    chk("post_rst_valid_1", 32'(out_valid_1), 1);
    chk("post_rst_data_1", 32'(out_data_1), 32'h00a5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
